// File: rtl/clk_gate_ctrl.sv
// Idle-hysteresis power controller for N_DOM clock-gate cells.
// Each domain gates after idle_thresh idle cycles, and wake-ups are granted one per cycle in round-robin order.
module clk_gate_ctrl #(
  parameter int N_DOM    = 4,
  parameter int CNT_W    = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_DOM-1:0] req,
  input  logic             force_on,
  input  logic [CNT_W-1:0] idle_thresh,
  output logic [N_DOM-1:0] pwr_en,
  output logic [N_DOM-1:0] ready,
  output logic [N_DOM-1:0] gated
);

  localparam int PTR_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam int WL_W  = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;

  typedef enum logic [1:0] {
    ST_ON,
    ST_OFF,
    ST_WAKE_PEND,
    ST_WAKE
  } dom_state_e;

  dom_state_e       state_q [N_DOM];
  dom_state_e       state_d [N_DOM];
  logic [CNT_W-1:0] cnt_q   [N_DOM];
  logic [CNT_W-1:0] cnt_d   [N_DOM];
  logic [WL_W-1:0]  wcnt_q  [N_DOM];
  logic [WL_W-1:0]  wcnt_d  [N_DOM];

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [N_DOM-1:0] pwr_en_q, pwr_en_d;
  logic [N_DOM-1:0] ready_q,  ready_d;
  logic [N_DOM-1:0] gated_q,  gated_d;

  logic [N_DOM-1:0] pend;
  logic [N_DOM-1:0] grant_oh;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_valid;

  always_comb begin
    for (int d = 0; d < N_DOM; d++) begin
      pend[d] = (state_q[d] == ST_WAKE_PEND);
    end
  end

  // Scan from the far end toward rr_ptr so the nearest pending domain wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = N_DOM - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % N_DOM;
      if (pend[idx]) begin
        grant_oh      = '0;
        grant_oh[idx] = 1'b1;
        grant_idx     = PTR_W'(idx);
        grant_valid   = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      if (int'(grant_idx) == N_DOM - 1) rr_ptr_d = '0;
      else                              rr_ptr_d = grant_idx + 1'b1;
    end
  end

  // The threshold compare is one bit wider so a saturated counter still reaches an all-ones threshold.
  always_comb begin
    for (int d = 0; d < N_DOM; d++) begin
      state_d[d] = state_q[d];
      cnt_d[d]   = cnt_q[d];
      wcnt_d[d]  = wcnt_q[d];
      case (state_q[d])
        ST_ON: begin
          if (req[d] || force_on) begin
            cnt_d[d] = '0;
          end else if ((idle_thresh != '0) &&
                       (({1'b0, cnt_q[d]} + (CNT_W+1)'(1)) >= {1'b0, idle_thresh})) begin
            state_d[d] = ST_OFF;
            cnt_d[d]   = '0;
          end else if (cnt_q[d] != '1) begin
            cnt_d[d] = cnt_q[d] + 1'b1;
          end
        end
        ST_OFF: begin
          if (req[d] || force_on) state_d[d] = ST_WAKE_PEND;
        end
        ST_WAKE_PEND: begin
          if (grant_oh[d]) begin
            state_d[d] = ST_WAKE;
            wcnt_d[d]  = WL_W'(WAKE_LAT - 1);
          end
        end
        ST_WAKE: begin
          if (wcnt_q[d] == '0) begin
            state_d[d] = ST_ON;
            cnt_d[d]   = '0;
          end else begin
            wcnt_d[d] = wcnt_q[d] - 1'b1;
          end
        end
        default: state_d[d] = ST_ON;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered values line up with the state register.
  always_comb begin
    for (int d = 0; d < N_DOM; d++) begin
      pwr_en_d[d] = (state_d[d] == ST_ON) || (state_d[d] == ST_WAKE);
      ready_d[d]  = (state_d[d] == ST_ON);
      gated_d[d]  = (state_d[d] == ST_OFF) || (state_d[d] == ST_WAKE_PEND);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < N_DOM; d++) begin
        state_q[d] <= ST_ON;
        cnt_q[d]   <= '0;
        wcnt_q[d]  <= '0;
      end
      rr_ptr_q <= '0;
      pwr_en_q <= '1;
      ready_q  <= '1;
      gated_q  <= '0;
    end else begin
      for (int d = 0; d < N_DOM; d++) begin
        state_q[d] <= state_d[d];
        cnt_q[d]   <= cnt_d[d];
        wcnt_q[d]  <= wcnt_d[d];
      end
      rr_ptr_q <= rr_ptr_d;
      pwr_en_q <= pwr_en_d;
      ready_q  <= ready_d;
      gated_q  <= gated_d;
    end
  end

  assign pwr_en = pwr_en_q;
  assign ready  = ready_q;
  assign gated  = gated_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Randomized and directed bench for clk_gate_ctrl.
// Compares against a timestamp-based reference model of the gating rules.
module tb_clk_gate_ctrl;

  localparam int N        = 4;
  localparam int CW       = 8;
  localparam int WAKE_LAT = 2;
  localparam int MON = 0, MOFF = 1, MPEND = 2, MWAKE = 3;

  logic          clk;
  logic          reset_n;
  logic [N-1:0]  req;
  logic          force_on;
  logic [CW-1:0] idle_thresh;
  logic [N-1:0]  pwr_en, ready, gated;

  int errors;
  int checks;

  int mMode [N];
  int mIdle [N];
  int mDone [N];
  int mPtr;
  int cyc;

  clk_gate_ctrl #(.N_DOM(N), .CNT_W(CW), .WAKE_LAT(WAKE_LAT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .force_on(force_on),
    .idle_thresh(idle_thresh),
    .pwr_en(pwr_en),
    .ready(ready),
    .gated(gated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: domains tracked by mode, idle run length and a wake-completion timestamp.
  function automatic void modelReset();
    for (int d = 0; d < N; d++) begin
      mMode[d] = MON;
      mIdle[d] = 0;
      mDone[d] = 0;
    end
    mPtr = 0;
  endfunction

  function automatic void modelEdge();
    int oldMode [N];
    int g;
    cyc++;
    for (int d = 0; d < N; d++) oldMode[d] = mMode[d];
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && oldMode[(mPtr + k) % N] == MPEND) g = (mPtr + k) % N;
    end
    if (g >= 0) mPtr = (g + 1) % N;
    for (int d = 0; d < N; d++) begin
      case (oldMode[d])
        MON: begin
          if (req[d] || force_on) mIdle[d] = 0;
          else if (idle_thresh != 0 && mIdle[d] + 1 >= int'(idle_thresh)) begin
            mMode[d] = MOFF;
            mIdle[d] = 0;
          end else mIdle[d] = (mIdle[d] + 1 > 255) ? 255 : mIdle[d] + 1;
        end
        MOFF:  if (req[d] || force_on) mMode[d] = MPEND;
        MPEND: if (d == g) begin
          mMode[d] = MWAKE;
          mDone[d] = cyc + WAKE_LAT;
        end
        default: if (cyc == mDone[d]) begin
          mMode[d] = MON;
          mIdle[d] = 0;
        end
      endcase
    end
  endfunction

  function automatic logic [3*N-1:0] expOut();
    logic [N-1:0] p, r, g;
    for (int d = 0; d < N; d++) begin
      p[d] = (mMode[d] == MON) || (mMode[d] == MWAKE);
      r[d] = (mMode[d] == MON);
      g[d] = (mMode[d] == MOFF) || (mMode[d] == MPEND);
    end
    return {p, r, g};
  endfunction

  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic test_reset();
    idle_thresh = 8'd1;
    req = '0;
    force_on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checks++;
      if ({pwr_en, ready, gated} !== expOut()) begin
        errors++;
        $display("[TB] FAIL reset_prerun: got %h expected %h", {pwr_en, ready, gated}, expOut());
      end
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    modelReset();
    checks++;
    if ({pwr_en, ready, gated} !== {4'hF, 4'hF, 4'h0}) begin
      errors++;
      $display("[TB] FAIL reset_async: got %h expected %h", {pwr_en, ready, gated}, {4'hF, 4'hF, 4'h0});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_gate();
    idle_thresh = 8'd3;
    req = 4'hF;
    for (int i = 0; i < 2; i++) applyStimulus();
    req = 4'hE;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus();
      checks++;
      if ({pwr_en, ready, gated} !== expOut()) begin
        errors++;
        $display("[TB] FAIL gate_model step %0d: got %h expected %h", i, {pwr_en, ready, gated}, expOut());
      end
      checks++;
      if ({pwr_en[0], gated[0]} !== ((i < 3) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("[TB] FAIL gate_timing step %0d: got %b expected %b", i, {pwr_en[0], gated[0]}, (i < 3) ? 2'b10 : 2'b01);
      end
    end
    req = 4'hF;
    for (int i = 0; i < 8; i++) applyStimulus();
    req = 4'hE;
    applyStimulus();
    applyStimulus();
    req = 4'hF;
    applyStimulus();
    req = 4'hE;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus();
      checks++;
      if ({pwr_en[0], gated[0]} !== ((i < 3) ? 2'b10 : 2'b01) || {pwr_en, ready, gated} !== expOut()) begin
        errors++;
        $display("[TB] FAIL gate_restart step %0d: got %h expected %h", i, {pwr_en, ready, gated}, expOut());
      end
    end
  endtask

  task automatic test_wake();
    idle_thresh = 8'd3;
    req = 4'hD;
    for (int i = 0; i < 8; i++) applyStimulus();
    req = 4'hF;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus();
      checks++;
      if ({pwr_en[1], ready[1], gated[1]} !== ((i == 1) ? 3'b001 : (i < 4) ? 3'b100 : 3'b110)) begin
        errors++;
        $display("[TB] FAIL wake step %0d: got %b expected %b", i, {pwr_en[1], ready[1], gated[1]},
                 (i == 1) ? 3'b001 : (i < 4) ? 3'b100 : 3'b110);
      end
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] expPwr [5];
    expPwr[0] = 4'h0;
    expPwr[1] = 4'h4;
    expPwr[2] = 4'hC;
    expPwr[3] = 4'hD;
    expPwr[4] = 4'hF;
    idle_thresh = 8'd1;
    req = '0;
    for (int i = 0; i < 3; i++) applyStimulus();
    req = 4'h2;
    applyStimulus();
    req = '0;
    for (int i = 0; i < 6; i++) applyStimulus();
    checks++;
    if (gated !== 4'hF) begin
      errors++;
      $display("[TB] FAIL contention_setup: got %h expected %h", gated, 4'hF);
    end
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checks++;
      if (pwr_en !== expPwr[i] || {pwr_en, ready, gated} !== expOut()) begin
        errors++;
        $display("[TB] FAIL contention step %0d: got %h expected %h", i, pwr_en, expPwr[i]);
      end
    end
  endtask

  task automatic test_force_on();
    idle_thresh = 8'd5;
    req = '0;
    force_on = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus();
    force_on = 1'b1;
    for (int i = 0; i < N + WAKE_LAT + 1; i++) applyStimulus();
    checks++;
    if (ready !== 4'hF || {pwr_en, ready, gated} !== expOut()) begin
      errors++;
      $display("[TB] FAIL force_converge: got %h expected %h", ready, 4'hF);
    end
    for (int i = 0; i < 10; i++) applyStimulus();
    force_on = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus();
      checks++;
      if (pwr_en !== ((i < 5) ? 4'hF : 4'h0)) begin
        errors++;
        $display("[TB] FAIL force_cnt_hold step %0d: got %h expected %h", i, pwr_en, (i < 5) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_thresh_zero();
    idle_thresh = 8'd0;
    req = 4'hF;
    for (int i = 0; i < 8; i++) applyStimulus();
    req = '0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus();
      checks++;
      if ({pwr_en, ready, gated} !== {4'hF, 4'hF, 4'h0}) begin
        errors++;
        $display("[TB] FAIL thresh_zero step %0d: got %h expected %h", i, {pwr_en, ready, gated}, {4'hF, 4'hF, 4'h0});
        break;
      end
    end
  endtask

  task automatic test_thresh_lower();
    idle_thresh = 8'd50;
    req = 4'hF;
    applyStimulus();
    req = '0;
    for (int i = 0; i < 20; i++) applyStimulus();
    checks++;
    if (pwr_en !== 4'hF) begin
      errors++;
      $display("[TB] FAIL thresh_lower_pre: got %h expected %h", pwr_en, 4'hF);
    end
    idle_thresh = 8'd5;
    applyStimulus();
    checks++;
    if (gated !== 4'hF || {pwr_en, ready, gated} !== expOut()) begin
      errors++;
      $display("[TB] FAIL thresh_lower: got %h expected %h", gated, 4'hF);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      req = 4'($urandom & $urandom & $urandom);
      if (i % 64 == 0) idle_thresh = 8'($urandom_range(0, 6));
      force_on = ($urandom_range(0, 40) == 0);
      applyStimulus();
      checks++;
      if ({pwr_en, ready, gated} !== expOut()) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("[TB] FAIL random cycle %0d: got %h expected %h", i, {pwr_en, ready, gated}, expOut());
      end
    end
    force_on = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    reset_n = 1'b0;
    req = '0;
    force_on = 1'b0;
    idle_thresh = 8'd0;
    modelReset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_gate();
    test_wake();
    test_contention();
    test_force_on();
    test_thresh_zero();
    test_thresh_lower();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
